// File: rtl/nn_acc_pkg.sv
// Shared constants for the accelerator stream front end: state encoding, default widths.
package nn_acc_pkg;

    localparam int DEF_DATA_WIDTH      = 128;
    localparam int DEF_BEATS_PER_FRAME = 7;
    localparam int FRAME_CNT_W         = 16;

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] SEND  = 2'd3;

    typedef enum logic [1:0] {
        ST_LOAD  = LOAD,
        ST_START = START,
        ST_WAIT  = WAIT,
        ST_SEND  = SEND
    } fsm_state_t;

endpackage

// File: rtl/axis_frame_ctrl.sv
// Loads one frame into the image buffer, kicks the core, returns its result as a 1-beat frame; TLAST check under AXIS_FRAME_CTRL_TLAST_CHECK_EN.
// Latency: last input beat t -> core_start t+1; core_done d -> result valid d+1.
// Backpressure: input ready only while loading; result held stable until downstream ready.
module axis_frame_ctrl
    import nn_acc_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BEATS_PER_FRAME = DEF_BEATS_PER_FRAME,
    parameter int ADDR_W          = $clog2(BEATS_PER_FRAME)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    input  logic                   S_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic                   M_AXIS_TLAST,
    output logic                   img_wr_en,
    output logic [ADDR_W-1:0]      img_wr_addr,
    output logic [DATA_WIDTH-1:0]  img_wr_data,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [DATA_WIDTH-1:0]  core_result,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   frame_err,
    input  logic                   err_clr
);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS_PER_FRAME - 1);

    fsm_state_t             state;
    logic [ADDR_W-1:0]      beat_cnt;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   m_vld_q;
    logic                   busy_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   in_hs;
    logic                   last_beat;

    assign S_AXIS_TREADY = (state == ST_LOAD);
    assign in_hs         = S_AXIS_TREADY & S_AXIS_TVALID;
    assign last_beat     = (beat_cnt == LAST_BEAT);

    assign img_wr_en     = in_hs;
    assign img_wr_addr   = beat_cnt;
    assign img_wr_data   = S_AXIS_TDATA;
    assign core_start    = (state == ST_START);

    assign M_AXIS_TVALID = m_vld_q;
    assign M_AXIS_TDATA  = res_q;
    assign M_AXIS_TLAST  = (state == ST_SEND);
    assign busy          = busy_q;
    assign frame_cnt     = frame_cnt_q;

    // Frames are delimited purely by beat count; TLAST only feeds the error flag.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= ST_LOAD;
            beat_cnt    <= '0;
            res_q       <= '0;
            m_vld_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_hs) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            busy_q   <= 1'b1;
                            state    <= ST_START;
                        end else begin
                            beat_cnt <= beat_cnt + ADDR_W'(1);
                        end
                    end
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        res_q   <= core_result;
                        m_vld_q <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (M_AXIS_TREADY) begin
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        m_vld_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

`ifdef AXIS_FRAME_CTRL_TLAST_CHECK_EN
    logic err_q;
    logic tlast_bad;

    assign tlast_bad = in_hs & (S_AXIS_TLAST != last_beat);
    assign frame_err = err_q;

    // A new error outranks a simultaneous clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q <= 1'b0;
        end else if (tlast_bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_tlast_chk;

    assign unused_tlast_chk = &{1'b0, S_AXIS_TLAST, err_clr};
    assign frame_err        = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_ctrl.sv
// Randomized frame-level bench for axis_frame_ctrl with a transaction-level reference model.
module tb_axis_frame_ctrl;

    localparam int DW  = 128;
    localparam int BPF = 7;
    localparam int AW  = 3;
`ifdef AXIS_FRAME_CTRL_TLAST_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TVALID;
    logic          S_AXIS_TREADY;
    logic          S_AXIS_TLAST;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY;
    logic          M_AXIS_TLAST;
    logic          img_wr_en;
    logic [AW-1:0] img_wr_addr;
    logic [DW-1:0] img_wr_data;
    logic          core_start;
    logic          core_done;
    logic [DW-1:0] core_result;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          frame_err;
    logic          err_clr;

    axis_frame_ctrl dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .core_start(core_start), .core_done(core_done), .core_result(core_result),
        .busy(busy), .frame_cnt(frame_cnt), .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Observed transactions, appended only; each frame indexes from its own base.
    int            wr_addr_q[$];
    logic [DW-1:0] wr_dat_q[$];
    logic [DW-1:0] out_dat_q[$];
    logic          out_last_q[$];
    int            start_cnt = 0;
    int            start_cyc = 0;
    int            last_hs_cyc = 0;

    always @(negedge ACLK) begin
        if (img_wr_en) begin
            wr_addr_q.push_back(int'(img_wr_addr));
            wr_dat_q.push_back(img_wr_data);
            if (img_wr_addr == AW'(BPF - 1)) last_hs_cyc <= cyc;
        end
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            out_dat_q.push_back(M_AXIS_TDATA);
            out_last_q.push_back(M_AXIS_TLAST);
        end
    end

    int            n_chk = 0;
    int            n_pass = 0;
    logic [15:0]   fc_exp = '0;
    bit            err_exp = 1'b0;
    logic [DW-1:0] exp_dat[BPF];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic do_reset();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        core_done     = 1'b0;
        err_clr       = 1'b0;
        ARESETN       = 1'b0;
        #1;
        check_val("rst_m_vld", M_AXIS_TVALID, 0);
        check_val("rst_m_last", M_AXIS_TLAST, 0);
        check_val("rst_m_dat", M_AXIS_TDATA, 0);
        check_val("rst_wr_en", img_wr_en, 0);
        check_val("rst_start", core_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_frame_cnt", frame_cnt, 0);
        check_val("rst_frame_err", frame_err, 0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        fc_exp  = '0;
        err_exp = 1'b0;
        check_val("rst_s_rdy", S_AXIS_TREADY, 1);
    endtask

    // abort: 0 = complete, 1 = reset during WAIT, 2 = reset during SEND stall
    task automatic run_frame(input bit fixed, input int gap_pct, input int bad_beat, input bit no_last,
                             input bit clr_on_bad, input int done_dly, input logic [DW-1:0] res,
                             input int stall, input bit stray, input int abort);
        int  wr_base, out_base, st_base, w;
        bit  tl, bad;
        wr_base  = wr_addr_q.size();
        out_base = out_dat_q.size();
        st_base  = start_cnt;
        for (int i = 0; i < BPF; i++)
            exp_dat[i] = fixed ? DW'(i + 1) : {$urandom, $urandom, $urandom, $urandom};

        for (int i = 0; i < BPF; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                S_AXIS_TVALID = 1'b0;
                @(posedge ACLK); #1;
            end
            tl = (i == BPF - 1) ? !no_last : (i == bad_beat);
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = exp_dat[i];
            S_AXIS_TLAST  = tl;
            core_done     = stray && (i == 3);
            core_result   = {$urandom, $urandom, $urandom, $urandom};
            err_clr       = clr_on_bad && (i == bad_beat);
            check_val("s_rdy_load", S_AXIS_TREADY, 1);
            bad = CHK_EN && (tl != (i == BPF - 1));
            @(posedge ACLK); #1;
            if (bad) err_exp = 1'b1;
            else if (err_clr) err_exp = 1'b0;
            core_done = 1'b0;
            err_clr   = 1'b0;
            check_val("frame_err", frame_err, err_exp);
        end
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        check_val("busy_start", busy, 1);
        check_val("s_rdy_start", S_AXIS_TREADY, 0);

        w = 0;
        while (start_cnt == st_base && w < 20) begin
            @(posedge ACLK); #1;
            w++;
        end
        check_val("start_seen", start_cnt - st_base, 1);
        check_val("start_lat", start_cyc, last_hs_cyc + 1);
        if (abort == 1) begin
            do_reset();
            return;
        end

        repeat (done_dly - 1) begin
            @(posedge ACLK); #1;
        end
        core_done   = 1'b1;
        core_result = res;
        @(posedge ACLK); #1;
        core_done   = 1'b0;
        core_result = {$urandom, $urandom, $urandom, $urandom};
        check_val("m_vld_lat", M_AXIS_TVALID, 1);
        check_val("m_last", M_AXIS_TLAST, 1);
        check_val("m_dat", M_AXIS_TDATA, res);

        for (int k = 0; k < stall; k++) begin
            if (stray && k == 0) begin
                core_done   = 1'b1;
                core_result = ~res;
            end
            @(posedge ACLK); #1;
            core_done = 1'b0;
            check_val("hold_dat", M_AXIS_TDATA, res);
            check_val("hold_vld", M_AXIS_TVALID, 1);
            check_val("s_rdy_send", S_AXIS_TREADY, 0);
        end
        if (abort == 2) begin
            do_reset();
            return;
        end

        M_AXIS_TREADY = 1'b1;
        @(posedge ACLK); #1;
        M_AXIS_TREADY = 1'b0;
        fc_exp = fc_exp + 16'd1;
        check_val("m_vld_drop", M_AXIS_TVALID, 0);
        check_val("s_rdy_back", S_AXIS_TREADY, 1);
        check_val("busy_idle", busy, 0);
        check_val("frame_cnt", frame_cnt, fc_exp);

        check_val("wr_count", wr_addr_q.size() - wr_base, BPF);
        for (int i = 0; i < BPF; i++) begin
            if (wr_base + i < wr_addr_q.size()) begin
                check_val("wr_addr", wr_addr_q[wr_base + i], i);
                check_val("wr_dat", wr_dat_q[wr_base + i], exp_dat[i]);
            end
        end
        check_val("start_cnt", start_cnt - st_base, 1);
        check_val("out_count", out_dat_q.size() - out_base, 1);
        if (out_dat_q.size() > out_base) begin
            check_val("out_dat", out_dat_q[out_base], res);
            check_val("out_last", out_last_q[out_base], 1);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge ACLK); #1;
        err_clr = 1'b0;
        err_exp = 1'b0;
        check_val("err_clr", frame_err, 0);
    endtask

    initial begin
        S_AXIS_TDATA  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_AXIS_TREADY = 1'b0;
        core_done     = 1'b0;
        core_result   = '0;
        err_clr       = 1'b0;
        #2;
        do_reset();

        run_frame(1, 0, -1, 0, 0, 10, DW'(8'hA5), 0, 0, 0);
        run_frame(0, 40, -1, 0, 0, 4, DW'(8'h3C), 5, 0, 0);
        run_frame(0, 20, -1, 0, 0, 3, {$urandom, $urandom, $urandom, $urandom}, 3, 1, 0);

        run_frame(0, 0, 2, 0, 0, 2, DW'(16'h1234), 0, 0, 0);
        run_frame(0, 0, -1, 1, 0, 2, DW'(16'h5678), 1, 0, 0);
        pulse_clr();
        run_frame(0, 10, 2, 0, 1, 2, DW'(16'h9ABC), 0, 0, 0);
        pulse_clr();

        run_frame(0, 0, -1, 0, 0, 1, DW'(8'h77), 0, 0, 0);
        for (int n = 0; n < 6; n++)
            run_frame(0, int'($urandom_range(0, 50)), -1, 0, 0, int'($urandom_range(1, 12)),
                      {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 0, 0);

        run_frame(0, 0, -1, 0, 0, 5, DW'(8'h11), 0, 0, 1);
        run_frame(0, 20, -1, 0, 0, 3, DW'(8'h22), 1, 0, 0);
        run_frame(0, 0, -1, 0, 0, 2, DW'(8'h33), 2, 0, 2);
        run_frame(0, 20, -1, 0, 0, 2, DW'(8'h44), 0, 0, 0);

        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge ACLK); #1;
        release dut.frame_cnt_q;
        check_val("preload", frame_cnt, 16'hFFFF);
        fc_exp = 16'hFFFF;
        run_frame(0, 0, -1, 0, 0, 2, DW'(8'h55), 0, 0, 0);
        check_val("wrap_zero", frame_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
